// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the I2C register writer: FSM states, register map
// offsets, STATUS bit positions and CMD field positions.
package i2c_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } i2c_state_e;

    localparam logic [1:0] CMD_ADDR    = 2'd0;
    localparam logic [1:0] STATUS_ADDR = 2'd1;

    localparam int BUSY_BIT   = 0;
    localparam int ACKERR_BIT = 1;

    localparam int DEV_LSB  = 16;
    localparam int DEV_MSB  = 22;
    localparam int REG_LSB  = 8;
    localparam int REG_MSB  = 15;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 7;

    localparam int         CNT_W     = 16;
    localparam logic [1:0] LAST_BYTE = 2'd2;

    function automatic logic [31:0] pack_cmd(input logic [6:0] dev,
                                             input logic [7:0] reg_byte,
                                             input logic [7:0] data);
        return {9'd0, dev, reg_byte, data};
    endfunction

    function automatic logic [31:0] pack_status(input logic ack_err, input logic busy);
        return {30'd0, ack_err, busy};
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period timebase: pulses qtick once every CLK_DIV cycles while enabled
// and tracks which of the four SCL quarters is current.
module i2c_qtick
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       restart,
    output logic       qtick,
    output logic [1:0] quarter
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       quarter_r;

    assign qtick   = en && (cnt_r == LAST_CNT);
    assign quarter = quarter_r;

    // Divider and quarter index; held at zero whenever the bus is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            quarter_r <= 2'd0;
        end else if (restart || !en) begin
            cnt_r     <= '0;
            quarter_r <= 2'd0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r     <= '0;
            quarter_r <= quarter_r + 2'd1;
        end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_reg_writer.sv
// Avalon-MM slave that turns one CMD write into a complete I2C register write
// (START, address+W, register, data, STOP) on an open-drain SDA line.
module i2c_reg_writer
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        i2c_scl,
    inout  wire         i2c_sda
);

    i2c_state_e state_r, state_n_s;
    logic       busy_r, busy_n_s;
    logic       ack_err_r, ack_set_s, ack_clr_s;
    logic [6:0] dev_r;
    logic [7:0] reg_byte_r, data_r;
    logic [7:0] shift_r, shift_n_s;
    logic [2:0] bit_cnt_r, bit_cnt_n_s;
    logic [1:0] byte_cnt_r, byte_cnt_n_s;
    logic       ack_bit_r, ack_bit_n_s;
    logic       scl_n_s, sda_oe_n_s, sda_oe_r;
    logic       cmd_wr_s, accept_s, qtick_s, last_q_s;
    logic [1:0] quarter_s;
    logic       unused_s;

    assign cmd_wr_s  = chipselect && !write_n && (address == CMD_ADDR);
    assign ack_clr_s = chipselect && !write_n && (address == STATUS_ADDR) && writedata[ACKERR_BIT];
    assign accept_s  = cmd_wr_s && !busy_r;
    assign last_q_s  = qtick_s && (quarter_s == 2'd3);
    assign i2c_sda   = sda_oe_r ? 1'b0 : 1'bz;
    assign unused_s  = ^{read_n, writedata[31:23]};

    i2c_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk     (clk),
        .reset   (reset),
        .en      (busy_r),
        .restart (accept_s),
        .qtick   (qtick_s),
        .quarter (quarter_s)
    );

    // Next-state logic and bus levels for the current phase/quarter
    always_comb begin
        state_n_s    = state_r;
        busy_n_s     = busy_r;
        shift_n_s    = shift_r;
        bit_cnt_n_s  = bit_cnt_r;
        byte_cnt_n_s = byte_cnt_r;
        ack_bit_n_s  = ack_bit_r;
        ack_set_s    = 1'b0;
        scl_n_s      = 1'b1;
        sda_oe_n_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n_s = ST_START;
                    busy_n_s  = 1'b1;
                    shift_n_s = {writedata[DEV_MSB:DEV_LSB], 1'b0};
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_START: begin
                scl_n_s    = (quarter_s != 2'd3);
                sda_oe_n_s = quarter_s[1];
                if (last_q_s) begin
                    state_n_s    = ST_SHIFT;
                    bit_cnt_n_s  = 3'd7;
                    byte_cnt_n_s = 2'd0;
                end else begin
                    state_n_s = ST_START;
                end
            end
            ST_SHIFT: begin
                scl_n_s    = quarter_s[1];
                sda_oe_n_s = !shift_r[7];
                if (last_q_s) begin
                    shift_n_s = {shift_r[6:0], 1'b0};
                    if (bit_cnt_r == 3'd0) begin
                        state_n_s = ST_ACK;
                    end else begin
                        bit_cnt_n_s = bit_cnt_r - 3'd1;
                    end
                end else begin
                    state_n_s = ST_SHIFT;
                end
            end
            ST_ACK: begin
                scl_n_s    = quarter_s[1];
                sda_oe_n_s = 1'b0;
                // SCL has been high for the whole of q2 when this sample is taken
                if (qtick_s && (quarter_s == 2'd2)) begin
                    ack_bit_n_s = i2c_sda;
                end else begin
                    ack_bit_n_s = ack_bit_r;
                end
                if (last_q_s) begin
                    if (ack_bit_r) begin
                        ack_set_s = 1'b1;
                        state_n_s = ST_STOP;
                    end else if (byte_cnt_r < LAST_BYTE) begin
                        shift_n_s    = (byte_cnt_r == 2'd0) ? reg_byte_r : data_r;
                        byte_cnt_n_s = byte_cnt_r + 2'd1;
                        bit_cnt_n_s  = 3'd7;
                        state_n_s    = ST_SHIFT;
                    end else begin
                        state_n_s = ST_STOP;
                    end
                end else begin
                    state_n_s = ST_ACK;
                end
            end
            ST_STOP: begin
                scl_n_s    = (quarter_s != 2'd0);
                sda_oe_n_s = !quarter_s[1];
                if (last_q_s) begin
                    state_n_s = ST_IDLE;
                    busy_n_s  = 1'b0;
                end else begin
                    state_n_s = ST_STOP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                busy_n_s  = 1'b0;
            end
        endcase
    end

    // FSM, datapath and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            shift_r    <= 8'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 2'd0;
            ack_bit_r  <= 1'b0;
            i2c_scl    <= 1'b1;
            sda_oe_r   <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            busy_r     <= busy_n_s;
            shift_r    <= shift_n_s;
            bit_cnt_r  <= bit_cnt_n_s;
            byte_cnt_r <= byte_cnt_n_s;
            ack_bit_r  <= ack_bit_n_s;
            i2c_scl    <= scl_n_s;
            sda_oe_r   <= sda_oe_n_s;
        end
    end

    // Latched command and sticky NACK flag (a set beats a same-cycle clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_r      <= 7'd0;
            reg_byte_r <= 8'd0;
            data_r     <= 8'd0;
            ack_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                dev_r      <= writedata[DEV_MSB:DEV_LSB];
                reg_byte_r <= writedata[REG_MSB:REG_LSB];
                data_r     <= writedata[DATA_MSB:DATA_LSB];
            end else begin
                dev_r      <= dev_r;
            end
            if (ack_set_s) begin
                ack_err_r <= 1'b1;
            end else if (ack_clr_s) begin
                ack_err_r <= 1'b0;
            end else begin
                ack_err_r <= ack_err_r;
            end
        end
    end

    // Read mux, registered every cycle from address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                CMD_ADDR:    readdata <= pack_cmd(dev_r, reg_byte_r, data_r);
                STATUS_ADDR: readdata <= pack_status(ack_err_r, busy_r);
                default:     readdata <= 32'd0;
            endcase
        end
    end

endmodule
